apb_spi_mst: RTL and testbench

APB3 slave that exposes a register-programmed SPI master (mode 0, single chip select) to the CPU bus.
- Software loads command, address, length and write data, then sets a start bit in CTRL.
- The block shifts out command, address and a data phase, optionally capturing read data into RDATA.
- Software polls CTRL until it reads 0.

---
 rtl/apb_spi_pkg.sv | 34 +++
 rtl/apb_spi_mst_if.sv | 38 +++
 rtl/spi_master_core.sv | 212 +++++++++++++++++++++
 rtl/apb_spi_mst.sv | 132 +++++++++++++
 tb/tb_apb_spi_mst.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_spi_pkg.sv
// -----------------------------------------------------------------------------
// apb_spi_pkg
// Shared definitions for the APB-programmed SPI master: register word
// indexes, CTRL bit positions and the serial engine state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package apb_spi_pkg;

    // Register word indexes on paddr
    localparam logic [3:0] REG_CMD   = 4'd0;
    localparam logic [3:0] REG_ADDR  = 4'd1;
    localparam logic [3:0] REG_LEN   = 4'd2;
    localparam logic [3:0] REG_WDATA = 4'd3;
    localparam logic [3:0] REG_RDATA = 4'd4;
    localparam logic [3:0] REG_CTRL  = 4'd5;

    // CTRL bit positions
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_RX_BIT    = 1;

    // Largest data phase in bits; longer LEN values are clamped to this
    localparam logic [5:0] MAX_DATA_BITS = 6'd32;

    // Serial engine states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_CMD      = 3'd2,
        ST_ADDR     = 3'd3,
        ST_DATA     = 3'd4,
        ST_CS_HOLD  = 3'd5
    } spi_state_e;

endpackage

// File: rtl/apb_spi_mst_if.sv
// -----------------------------------------------------------------------------
// apb_spi_mst_if
// APB3 bus bundle for apb_spi_mst. Signal names keep the slave-side
// direction suffixes so they match the block's documented port list.
//   slave  modport : used by apb_spi_mst
//   master modport : used by whatever drives the bus (CPU side, bench)
// Signals: psel_i, penable_i, paddr_i[3:0], pwrite_i, pwdata_i[31:0],
//          prdata_o[31:0], pready_o
// -----------------------------------------------------------------------------
interface apb_spi_mst_if;
    logic        psel_i;
    logic        penable_i;
    logic [3:0]  paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;

    modport slave (
        input  psel_i,
        input  penable_i,
        input  paddr_i,
        input  pwrite_i,
        input  pwdata_i,
        output prdata_o,
        output pready_o
    );

    modport master (
        output psel_i,
        output penable_i,
        output paddr_i,
        output pwrite_i,
        output pwdata_i,
        input  prdata_o,
        input  pready_o
    );
endinterface

// File: rtl/spi_master_core.sv
// -----------------------------------------------------------------------------
// spi_master_core
// Mode-0 SPI engine: clock divider, framing FSM and receive shift register.
// A transfer is chip-select setup, CMD_W command bits, ADDR_W address bits,
// an optional data phase (TX from wdata_i or RX into rdata_o), then hold.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   start_i          one-cycle start request (only honoured while idle)
//   rx_i             data phase direction, 1 = capture sdi into rdata_o
//   cmd_i, addr_i    command / address words, held stable while busy
//   len_i            data phase length in bits (clamped to 32)
//   wdata_i          transmit data, LSB-aligned
//   sdi_i            serial data in
//   busy_o           high from start until chip select is released
//   rdata_o          received data, right-aligned
//   sclk_o, sdo_o, cs_n_o  SPI pins (registered)
// -----------------------------------------------------------------------------
module spi_master_core
    import apb_spi_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int CMD_W   = 8,
    parameter int ADDR_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              rx_i,
    input  logic [CMD_W-1:0]  cmd_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [5:0]        len_i,
    input  logic [31:0]       wdata_i,
    input  logic              sdi_i,
    output logic              busy_o,
    output logic [31:0]       rdata_o,
    output logic              sclk_o,
    output logic              sdo_o,
    output logic              cs_n_o
);

    localparam logic [8:0] HALF_LOAD = 9'(CLK_DIV - 1);
    // Hold covers the low half-period after the last falling edge plus
    // CLK_DIV cycles of chip-select hold.
    localparam logic [8:0] TAIL_LOAD = 9'(2 * CLK_DIV - 1);
    localparam logic [5:0] CMD_LAST  = 6'(CMD_W - 1);
    localparam logic [5:0] ADDR_LAST = 6'(ADDR_W - 1);

    spi_state_e  state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        sclk_q, sclk_d;
    logic        sdo_q, sdo_d;
    logic        cs_n_q, cs_n_d;
    logic [31:0] rdata_q, rdata_d;
    logic [5:0]  len_eff_s;
    logic        spi_rx_en;

    // Bit driven on sdo for a given phase and bit index (MSB first)
    function automatic logic tx_bit(
        input spi_state_e        st,
        input logic [5:0]        idx,
        input logic [CMD_W-1:0]  c,
        input logic [ADDR_W-1:0] a,
        input logic [31:0]       w,
        input logic              rx
    );
        logic [CMD_W-1:0]  c_sh;
        logic [ADDR_W-1:0] a_sh;
        logic [31:0]       w_sh;
        logic              bit_v;
        c_sh = c >> idx;
        a_sh = a >> idx;
        w_sh = w >> idx;
        case (st)
            ST_CMD:  bit_v = c_sh[0];
            ST_ADDR: bit_v = a_sh[0];
            ST_DATA: bit_v = rx ? 1'b0 : w_sh[0];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    assign len_eff_s = (len_i > MAX_DATA_BITS) ? MAX_DATA_BITS : len_i;
    assign spi_rx_en = (state_q == ST_DATA) && rx_i;
    assign busy_o    = (state_q != ST_IDLE);
    assign rdata_o   = rdata_q;
    assign sclk_o    = sclk_q;
    assign sdo_o     = sdo_q;
    assign cs_n_o    = cs_n_q;

    // Next-state, divider, bit counter and pin logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        cs_n_d    = cs_n_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                cs_n_d = 1'b1;
                sdo_d  = 1'b0;
                if (start_i) begin
                    state_d   = ST_CS_SETUP;
                    cnt_d     = HALF_LOAD;
                    bit_cnt_d = CMD_LAST;
                    cs_n_d    = 1'b0;
                    sdo_d     = tx_bit(ST_CMD, CMD_LAST, cmd_i, addr_i, wdata_i, rx_i);
                    rdata_d   = 32'h0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CS_SETUP: begin
                if (cnt_q == 9'd0) begin
                    // First rising edge; first command bit already on sdo
                    state_d = ST_CMD;
                    sclk_d  = 1'b1;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (cnt_q != 9'd0) begin
                    cnt_d = cnt_q - 9'd1;
                end else if (!sclk_q) begin
                    // Rising-edge event: sample sdi in an RX data phase
                    cnt_d  = HALF_LOAD;
                    sclk_d = 1'b1;
                    if (spi_rx_en) begin
                        rdata_d = {rdata_q[30:0], sdi_i};
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    // Falling-edge event: present the next bit or move phase
                    cnt_d  = HALF_LOAD;
                    sclk_d = 1'b0;
                    if (bit_cnt_q != 6'd0) begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                        sdo_d     = tx_bit(state_q, bit_cnt_q - 6'd1, cmd_i, addr_i, wdata_i, rx_i);
                    end else begin
                        case (state_q)
                            ST_CMD: begin
                                state_d   = ST_ADDR;
                                bit_cnt_d = ADDR_LAST;
                                sdo_d     = tx_bit(ST_ADDR, ADDR_LAST, cmd_i, addr_i, wdata_i, rx_i);
                            end
                            ST_ADDR: begin
                                if (len_eff_s != 6'd0) begin
                                    state_d   = ST_DATA;
                                    bit_cnt_d = len_eff_s - 6'd1;
                                    sdo_d     = tx_bit(ST_DATA, len_eff_s - 6'd1, cmd_i, addr_i, wdata_i, rx_i);
                                end else begin
                                    state_d = ST_CS_HOLD;
                                    cnt_d   = TAIL_LOAD;
                                    sdo_d   = 1'b0;
                                end
                            end
                            default: begin
                                state_d = ST_CS_HOLD;
                                cnt_d   = TAIL_LOAD;
                                sdo_d   = 1'b0;
                            end
                        endcase
                    end
                end
            end
            ST_CS_HOLD: begin
                if (cnt_q == 9'd0) begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                    sclk_d  = 1'b0;
                    sdo_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                sdo_d   = 1'b0;
            end
        endcase
    end

    // State and pin registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 9'd0;
            bit_cnt_q <= 6'd0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            cs_n_q    <= cs_n_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: rtl/apb_spi_mst.sv
// -----------------------------------------------------------------------------
// apb_spi_mst
// APB3 slave register file in front of a mode-0 SPI master. Software loads
// CMD/ADDR/LEN/WDATA, writes CTRL.START, then polls CTRL until it reads 0.
// Ports:
//   pclk_i, rst_i   clock, synchronous active-high reset
//   apb             APB3 slave bundle (zero wait states, combinational read)
//   spi_clk_o       SPI clock, idles low
//   spi_sdo_o       serial data out
//   spi_cs_n_o      chip select, active low
//   spi_sdi_i       serial data in
// -----------------------------------------------------------------------------
module apb_spi_mst
    import apb_spi_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int CMD_W   = 8,
    parameter int ADDR_W  = 8
) (
    input  logic            pclk_i,
    input  logic            rst_i,
    apb_spi_mst_if.slave    apb,
    output logic            spi_clk_o,
    output logic            spi_sdo_o,
    output logic            spi_cs_n_o,
    input  logic            spi_sdi_i
);

    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rx_q, rx_d;
    logic              wr_s;
    logic              reg_wr_s;
    logic              start_s;
    logic              busy_s;
    logic [31:0]       rdata_s;
    logic [31:0]       prdata_s;

    // All configuration is frozen while a transfer runs
    assign wr_s     = apb.psel_i & apb.penable_i & apb.pwrite_i;
    assign reg_wr_s = wr_s & ~busy_s;
    assign apb.pready_o = 1'b1;
    assign apb.prdata_o = prdata_s;

    // Register write decode and start request
    always_comb begin
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        rx_d    = rx_q;
        start_s = 1'b0;
        if (reg_wr_s) begin
            case (apb.paddr_i)
                REG_CMD:   cmd_d   = apb.pwdata_i[CMD_W-1:0];
                REG_ADDR:  addr_d  = apb.pwdata_i[ADDR_W-1:0];
                REG_LEN:   len_d   = apb.pwdata_i[5:0];
                REG_WDATA: wdata_d = apb.pwdata_i;
                REG_CTRL: begin
                    if (apb.pwdata_i[CTRL_START_BIT]) begin
                        start_s = 1'b1;
                        rx_d    = apb.pwdata_i[CTRL_RX_BIT];
                    end else begin
                        start_s = 1'b0;
                    end
                end
                default: start_s = 1'b0;  // RDATA and unmapped: ignored
            endcase
        end else begin
            start_s = 1'b0;
        end
    end

    // Read mux; RX is masked with BUSY so both bits drop together
    always_comb begin
        prdata_s = 32'h0;
        if (apb.psel_i && !apb.pwrite_i) begin
            case (apb.paddr_i)
                REG_CMD:   prdata_s = 32'(cmd_q);
                REG_ADDR:  prdata_s = 32'(addr_q);
                REG_LEN:   prdata_s = 32'(len_q);
                REG_WDATA: prdata_s = wdata_q;
                REG_RDATA: prdata_s = rdata_s;
                REG_CTRL:  prdata_s = {30'h0, rx_q & busy_s, busy_s};
                default:   prdata_s = 32'h0;
            endcase
        end else begin
            prdata_s = 32'h0;
        end
    end

    // Configuration registers
    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            cmd_q   <= '0;
            addr_q  <= '0;
            len_q   <= 6'd0;
            wdata_q <= 32'h0;
            rx_q    <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            rx_q    <= rx_d;
        end
    end

    spi_master_core #(
        .CLK_DIV (CLK_DIV),
        .CMD_W   (CMD_W),
        .ADDR_W  (ADDR_W)
    ) spi_master (
        .clk_i   (pclk_i),
        .rst_i   (rst_i),
        .start_i (start_s),
        .rx_i    (rx_q),
        .cmd_i   (cmd_q),
        .addr_i  (addr_q),
        .len_i   (len_q),
        .wdata_i (wdata_q),
        .sdi_i   (spi_sdi_i),
        .busy_o  (busy_s),
        .rdata_o (rdata_s),
        .sclk_o  (spi_clk_o),
        .sdo_o   (spi_sdo_o),
        .cs_n_o  (spi_cs_n_o)
    );

endmodule

// File: tb/tb_apb_spi_mst.sv
// -----------------------------------------------------------------------------
// tb_apb_spi_mst
// Self-checking bench for apb_spi_mst (CLK_DIV=1, CMD_W=8, ADDR_W=8).
// Expected serial frames and read data are queued when a transfer is
// started and compared when chip select is released / RDATA is read.
// -----------------------------------------------------------------------------
module tb_apb_spi_mst;
    import apb_spi_pkg::*;

    typedef struct {
        int          edges;
        logic [63:0] bits;
    } xfer_t;

    logic pclk_i;
    logic rst_i;
    logic spi_clk_o;
    logic spi_sdo_o;
    logic spi_cs_n_o;
    logic spi_sdi_i;

    apb_spi_mst_if apb_if ();

    apb_spi_mst #(
        .CLK_DIV (1),
        .CMD_W   (8),
        .ADDR_W  (8)
    ) dut (
        .pclk_i     (pclk_i),
        .rst_i      (rst_i),
        .apb        (apb_if),
        .spi_clk_o  (spi_clk_o),
        .spi_sdo_o  (spi_sdo_o),
        .spi_cs_n_o (spi_cs_n_o),
        .spi_sdi_i  (spi_sdi_i)
    );

    int          chk_cnt = 0;
    int          err_cnt = 0;
    int          cycle_cnt = 0;
    int          last_wr_cyc = 0;
    int          mon_end_cyc = 0;
    int          mon_edges = 0;
    int          mon_done = 0;
    int          rx_sdo_bad = 0;
    int          rx_idx = 0;
    logic [63:0] mon_bits = 64'h0;
    logic [15:0] rx_pat = 16'h0;
    xfer_t       exp_xfer_q[$];
    logic [31:0] exp_rd_q[$];

    initial pclk_i = 1'b0;
    always #5 pclk_i = ~pclk_i;

    always @(posedge pclk_i) cycle_cnt <= cycle_cnt + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge pclk_i); #1;
        last_wr_cyc       = cycle_cnt;
        apb_if.psel_i     = 1'b1;
        apb_if.penable_i  = 1'b0;
        apb_if.paddr_i    = a;
        apb_if.pwrite_i   = 1'b1;
        apb_if.pwdata_i   = d;
        @(posedge pclk_i); #1;
        apb_if.penable_i  = 1'b1;
        @(posedge pclk_i); #1;
        apb_if.psel_i     = 1'b0;
        apb_if.penable_i  = 1'b0;
        apb_if.pwrite_i   = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
        @(posedge pclk_i); #1;
        apb_if.psel_i     = 1'b1;
        apb_if.penable_i  = 1'b0;
        apb_if.paddr_i    = a;
        apb_if.pwrite_i   = 1'b0;
        @(posedge pclk_i); #1;
        apb_if.penable_i  = 1'b1;
        #1;
        d = apb_if.prdata_o;
        @(posedge pclk_i); #1;
        apb_if.psel_i     = 1'b0;
        apb_if.penable_i  = 1'b0;
    endtask

    task automatic wait_xfer(input int done0);
        int n;
        n = 0;
        while (mon_done == done0 && n < 1000) begin
            @(posedge pclk_i); #1;
            n++;
        end
        check_eq("xfer_done", 64'(mon_done), 64'(done0 + 1));
    endtask

    // Serial monitor: record sdo on every rising spi_clk while selected
    always begin
        @(posedge spi_clk_o); #1;
        if (!spi_cs_n_o) begin
            mon_bits = {mon_bits[62:0], spi_sdo_o};
            mon_edges++;
            if (dut.spi_master.spi_rx_en && spi_sdo_o !== 1'b0) rx_sdo_bad++;
        end
    end

    // Frame scoreboard: compare when chip select is released
    always begin
        xfer_t x;
        @(posedge spi_cs_n_o); #1;
        if (rst_i) begin
            mon_edges = 0;
        end else if (exp_xfer_q.size() == 0) begin
            check_eq("unexpected_xfer", 64'(mon_edges), 64'h0);
        end else begin
            x = exp_xfer_q.pop_front();
            check_eq("edges", 64'(mon_edges), 64'(x.edges));
            check_eq("frame_bits", mon_bits, x.bits);
        end
        mon_end_cyc = cycle_cnt;
        mon_edges   = 0;
        mon_bits    = 64'h0;
        mon_done++;
    end

    // SPI slave model: present the next RX bit after each falling edge
    always begin
        @(negedge spi_clk_o); #1;
        if (dut.spi_master.spi_rx_en === 1'b1 && rx_idx > 0) begin
            rx_idx    = rx_idx - 1;
            spi_sdi_i = rx_pat[rx_idx];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int done0;
        int ctrl_cyc;
        int n;

        rst_i            = 1'b1;
        spi_sdi_i        = 1'b0;
        apb_if.psel_i    = 1'b0;
        apb_if.penable_i = 1'b0;
        apb_if.paddr_i   = 4'd0;
        apb_if.pwrite_i  = 1'b0;
        apb_if.pwdata_i  = 32'h0;
        repeat (5) @(posedge pclk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        check_eq("rst_cs_n", 64'(spi_cs_n_o), 64'h1);
        check_eq("rst_spi_clk", 64'(spi_clk_o), 64'h0);
        check_eq("rst_pready", 64'(apb_if.pready_o), 64'h1);
        check_eq("rst_prdata_idle", 64'(apb_if.prdata_o), 64'h0);
        apb_read(REG_CTRL, rd);
        check_eq("rst_ctrl", 64'(rd), 64'h0);
        apb_read(REG_RDATA, rd);
        check_eq("rst_rdata", 64'(rd), 64'h0);

        // Register readback
        apb_write(REG_CMD, 32'h0A);
        apb_write(REG_ADDR, 32'h0B);
        apb_write(REG_LEN, 32'd16);
        apb_write(REG_WDATA, 32'hA001);
        apb_write(REG_RDATA, 32'h1234);
        apb_read(REG_CMD, rd);   check_eq("rb_cmd", 64'(rd), 64'h0A);
        apb_read(REG_ADDR, rd);  check_eq("rb_addr", 64'(rd), 64'h0B);
        apb_read(REG_LEN, rd);   check_eq("rb_len", 64'(rd), 64'd16);
        apb_read(REG_WDATA, rd); check_eq("rb_wdata", 64'(rd), 64'hA001);
        apb_read(REG_RDATA, rd); check_eq("rb_rdata_ro", 64'(rd), 64'h0);
        apb_read(4'd7, rd);      check_eq("rb_unmapped", 64'(rd), 64'h0);

        // CTRL write without START does nothing
        apb_write(REG_CTRL, 32'h2);
        apb_read(REG_CTRL, rd);  check_eq("ctrl_nostart", 64'(rd), 64'h0);

        // TX transfer: 32 bits, 66 pclk of chip select plus the 2-cycle write
        exp_xfer_q.push_back('{edges: 32, bits: 64'h0A0BA001});
        done0 = mon_done;
        apb_write(REG_CTRL, 32'h1);
        ctrl_cyc = last_wr_cyc;
        apb_read(REG_CTRL, rd);  check_eq("tx_ctrl_busy", 64'(rd), 64'h1);
        wait_xfer(done0);
        check_eq("tx_duration", 64'(mon_end_cyc - ctrl_cyc), 64'd68);
        apb_read(REG_CTRL, rd);  check_eq("tx_ctrl_done", 64'(rd), 64'h0);

        // RX transfer
        apb_write(REG_CMD, 32'h0B);
        rx_pat = 16'h5A3C;
        rx_idx = 16;
        rx_sdo_bad = 0;
        exp_xfer_q.push_back('{edges: 32, bits: 64'h0B0B0000});
        exp_rd_q.push_back(32'h00005A3C);
        done0 = mon_done;
        apb_write(REG_CTRL, 32'h3);
        apb_read(REG_CTRL, rd);  check_eq("rx_ctrl_busy", 64'(rd), 64'h3);
        wait_xfer(done0);
        apb_read(REG_CTRL, rd);  check_eq("rx_ctrl_done", 64'(rd), 64'h0);
        apb_read(REG_RDATA, rd); check_eq("rx_rdata", 64'(rd), 64'(exp_rd_q.pop_front()));
        check_eq("rx_sdo_zero", 64'(rx_sdo_bad), 64'h0);
        check_eq("rx_bits_used", 64'(rx_idx), 64'h0);

        // Busy protection: restart and WDATA writes mid-transfer are ignored
        apb_write(REG_CMD, 32'h0A);
        exp_xfer_q.push_back('{edges: 32, bits: 64'h0A0BA001});
        done0 = mon_done;
        apb_write(REG_CTRL, 32'h1);
        repeat (10) @(posedge pclk_i);
        apb_write(REG_CTRL, 32'h1);
        apb_write(REG_WDATA, 32'hFFFF);
        wait_xfer(done0);
        apb_read(REG_WDATA, rd); check_eq("busy_wdata", 64'(rd), 64'hA001);
        repeat (20) @(posedge pclk_i);
        #1;
        check_eq("busy_no_restart_cs", 64'(spi_cs_n_o), 64'h1);
        check_eq("busy_no_restart_cnt", 64'(mon_done), 64'(done0 + 1));

        // LEN = 0: command and address only
        apb_write(REG_LEN, 32'd0);
        exp_xfer_q.push_back('{edges: 16, bits: 64'h0A0B});
        done0 = mon_done;
        apb_write(REG_CTRL, 32'h1);
        wait_xfer(done0);

        // LEN = 40: clamped to 32 data bits
        apb_write(REG_LEN, 32'd40);
        apb_write(REG_WDATA, 32'h12345678);
        exp_xfer_q.push_back('{edges: 48, bits: 64'h0A0B12345678});
        done0 = mon_done;
        apb_write(REG_CTRL, 32'h1);
        wait_xfer(done0);
        apb_read(REG_CTRL, rd);  check_eq("len40_ctrl_done", 64'(rd), 64'h0);

        // Reset during the address phase
        apb_write(REG_LEN, 32'd16);
        apb_write(REG_CTRL, 32'h1);
        n = 0;
        while (mon_edges < 10 && n < 500) begin
            @(posedge pclk_i); #1;
            n++;
        end
        check_eq("rst_mid_reached_addr", 64'(mon_edges >= 10), 64'h1);
        check_eq("rst_mid_cs_low", 64'(spi_cs_n_o), 64'h0);
        rst_i = 1'b1;
        @(posedge pclk_i); #1;
        check_eq("rst_mid_cs_n", 64'(spi_cs_n_o), 64'h1);
        check_eq("rst_mid_spi_clk", 64'(spi_clk_o), 64'h0);
        apb_if.psel_i    = 1'b1;
        apb_if.penable_i = 1'b0;
        apb_if.pwrite_i  = 1'b0;
        apb_if.paddr_i   = REG_CTRL;
        #1;
        check_eq("rst_mid_ctrl", 64'(apb_if.prdata_o), 64'h0);
        @(posedge pclk_i); #1;
        apb_if.psel_i = 1'b0;
        rst_i = 1'b0;
        repeat (5) @(posedge pclk_i);
        #1;
        check_eq("rst_mid_stays_idle", 64'(spi_cs_n_o), 64'h1);
        check_eq("scoreboard_empty", 64'(exp_xfer_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
